alu_arbiter: RTL

Two-port round-robin arbiter that shares the single pipelined floating-point `alu` (opcode 0 = add, 1 = multiply) between two requesters. It accepts operations over a valid/ready handshake and issues at most one per cycle to the ALU. It records each issued operation's owner in an in-order tag FIFO and routes every ALU result, with its overflow flag, back to the requester that issued it. It sits directly in front of `alu` and drives that block's `i_vld`/`opcode`/`i_a`/`i_b`.

---
 rtl/alu_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter sharing one pipelined FP alu
// Owner tags ride an in-order FIFO so each alu result is routed back to its issuer.
module alu_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_vld,
    output logic        r0_rdy,
    input  logic        r0_op,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    output logic [31:0] r0_res,
    output logic        r0_res_vld,
    output logic        r0_ovf,
    input  logic        r1_vld,
    output logic        r1_rdy,
    input  logic        r1_op,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    output logic [31:0] r1_res,
    output logic        r1_res_vld,
    output logic        r1_ovf,
    output logic        alu_vld,
    output logic        alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_res,
    input  logic        alu_res_vld,
    input  logic        alu_ovf,
    output logic        stray_err
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [PW:0]      cnt;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [DEPTH-1:0] tag_mem;
    logic             last;
    logic             credit;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             pop;
    logic             head_tag;

    // Credit looks only at registered cnt, so a pop never frees a slot in its own cycle.
    assign credit   = (cnt < DEPTH_C);
    assign accept   = grant0 | grant1;
    assign pop      = alu_res_vld & (cnt != '0);
    assign head_tag = tag_mem[rd_ptr];
    assign r0_rdy   = grant0;
    assign r1_rdy   = grant1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && credit) begin
            if (r0_vld && (!r1_vld || last)) begin
                grant0 = 1'b1;
            end else if (r1_vld) begin
                grant1 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tag_mem    <= '0;
            last       <= 1'b1;
            alu_vld    <= 1'b0;
            alu_op     <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            r0_res     <= '0;
            r0_res_vld <= 1'b0;
            r0_ovf     <= 1'b0;
            r1_res     <= '0;
            r1_res_vld <= 1'b0;
            r1_ovf     <= 1'b0;
            stray_err  <= 1'b0;
        end else begin
            alu_vld <= accept;
            if (accept) begin
                alu_op          <= grant1 ? r1_op : r0_op;
                alu_a           <= grant1 ? r1_a  : r0_a;
                alu_b           <= grant1 ? r1_b  : r0_b;
                tag_mem[wr_ptr] <= grant1;
                wr_ptr          <= wr_ptr + 1'b1;
                last            <= grant1;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            r0_res_vld <= pop & ~head_tag;
            r1_res_vld <= pop & head_tag;
            if (pop && !head_tag) begin
                r0_res <= alu_res;
                r0_ovf <= alu_ovf;
            end
            if (pop && head_tag) begin
                r1_res <= alu_res;
                r1_ovf <= alu_ovf;
            end

            // A result with nothing outstanding is dropped and latched as an error.
            if (alu_res_vld && cnt == '0) begin
                stray_err <= 1'b1;
            end

            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule
